// File: rtl/aes_pkg.sv
// Shared definitions for the AES core controller slice.
// Contents:
//   ctrl_state_e      - sequencer state encoding
//   AES_128/256_*     - keylen encodings as presented on the host port
//   ENCIPHER/DECIPHER - encdec encodings as presented on the host port
//   sbox_owner_is_km  - decode of which client owns the shared S-box port
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY_INIT  = 3'd1,
        ST_KEY_WAIT  = 3'd2,
        ST_BLK_START = 3'd3,
        ST_BLK_WAIT  = 3'd4
    } ctrl_state_e;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;
    localparam logic ENCIPHER        = 1'b1;
    localparam logic DECIPHER        = 1'b0;

    // The key memory owns the S-box only while it is being expanded;
    // every other state hands the port to the encipher datapath.
    function automatic logic sbox_owner_is_km(input ctrl_state_e st);
        return (st == ST_KEY_INIT) || (st == ST_KEY_WAIT);
    endfunction

endpackage

// File: rtl/aes_sbox_arb.sv
// Combinational arbitration of the single shared 32-bit S-box word port.
// Ports:
//   km_owner      in   1 = key memory drives the S-box, 0 = encipher
//   km_sboxw      in   request word from key memory
//   enc_sboxw     in   request word from encipher
//   sboxw         out  word presented to the shared S-box
//   new_sboxw     in   substituted word returned by the S-box
//   km_new_sboxw  out  substituted word to key memory
//   enc_new_sboxw out  substituted word to encipher
module aes_sbox_arb (
    input  logic        km_owner,
    input  logic [31:0] km_sboxw,
    input  logic [31:0] enc_sboxw,
    output logic [31:0] sboxw,
    input  logic [31:0] new_sboxw,
    output logic [31:0] km_new_sboxw,
    output logic [31:0] enc_new_sboxw
);

    // Request mux: zero added latency, owner chosen purely from controller state.
    always_comb begin
        sboxw = 32'h0000_0000;
        if (km_owner) begin
            sboxw = km_sboxw;
        end else begin
            sboxw = enc_sboxw;
        end
    end

    // The non-owner simply ignores the returned word, so fan-out is unconditional.
    assign km_new_sboxw  = new_sboxw;
    assign enc_new_sboxw = new_sboxw;

endmodule

// File: rtl/aes_core_ctrl.sv
// Top-level sequencer for the AES core: key expansion and single-block
// encipher/decipher launch, plus shared S-box arbitration.
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   init, next            host command pulses
//   encdec, keylen        command qualifiers (sampled with next / init)
//   ready, key_valid,
//   result_valid, key_err registered host status
//   km_*                  key memory handshake, keylen and round index
//   enc_*, dec_*          datapath start strobes, ready and round inputs
//   *sboxw                shared S-box request/response routing
module aes_core_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        next,
    input  logic        encdec,
    input  logic        keylen,
    output logic        ready,
    output logic        key_valid,
    output logic        result_valid,
    output logic        key_err,
    output logic        km_init,
    output logic        km_keylen,
    input  logic        km_ready,
    output logic [3:0]  km_round,
    output logic        enc_next,
    output logic        dec_next,
    input  logic        enc_ready,
    input  logic        dec_ready,
    input  logic [3:0]  enc_round,
    input  logic [3:0]  dec_round,
    input  logic [31:0] km_sboxw,
    input  logic [31:0] enc_sboxw,
    output logic [31:0] sboxw,
    input  logic [31:0] new_sboxw,
    output logic [31:0] km_new_sboxw,
    output logic [31:0] enc_new_sboxw
);

    localparam int CNT_W = (KEY_TIMEOUT > 2) ? $clog2(KEY_TIMEOUT) : 1;

    ctrl_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             seen_low;
    logic             encdec_reg;
    logic             sel_ready;
    logic             km_owner;

    // Only the datapath chosen at launch is watched for completion.
    assign sel_ready = encdec_reg ? enc_ready : dec_ready;

    // Strobes decode state directly, so they drop as soon as reset clears state.
    assign km_init  = (state == ST_KEY_INIT);
    assign enc_next = (state == ST_BLK_START) &&  encdec_reg;
    assign dec_next = (state == ST_BLK_START) && !encdec_reg;

    assign km_round = encdec_reg ? enc_round : dec_round;
    assign km_owner = sbox_owner_is_km(state);

    aes_sbox_arb u_sbox_arb (
        .km_owner      (km_owner),
        .km_sboxw      (km_sboxw),
        .enc_sboxw     (enc_sboxw),
        .sboxw         (sboxw),
        .new_sboxw     (new_sboxw),
        .km_new_sboxw  (km_new_sboxw),
        .enc_new_sboxw (enc_new_sboxw)
    );

    // Sequencer FSM with registered host status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            ready        <= 1'b1;
            key_valid    <= 1'b0;
            result_valid <= 1'b0;
            key_err      <= 1'b0;
            km_keylen    <= AES_128_BIT_KEY;
            encdec_reg   <= DECIPHER;
            cnt          <= {CNT_W{1'b0}};
            seen_low     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // init has priority; a simultaneous next is dropped.
                    if (init) begin
                        km_keylen    <= keylen;
                        key_valid    <= 1'b0;
                        key_err      <= 1'b0;
                        result_valid <= 1'b0;
                        ready        <= 1'b0;
                        state        <= ST_KEY_INIT;
                    end else if (next && key_valid) begin
                        encdec_reg   <= encdec;
                        result_valid <= 1'b0;
                        ready        <= 1'b0;
                        state        <= ST_BLK_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_KEY_INIT: begin
                    cnt      <= {CNT_W{1'b0}};
                    seen_low <= 1'b0;
                    state    <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    // km_ready must be seen low first, otherwise a stale
                    // ready from the previous key would end the wait at once.
                    if (!km_ready) begin
                        seen_low <= 1'b1;
                    end else begin
                        seen_low <= seen_low;
                    end
                    if (km_ready && seen_low) begin
                        key_valid <= 1'b1;
                        ready     <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (cnt == CNT_W'(KEY_TIMEOUT - 1)) begin
                        key_err <= 1'b1;
                        ready   <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BLK_START: begin
                    seen_low <= 1'b0;
                    state    <= ST_BLK_WAIT;
                end
                ST_BLK_WAIT: begin
                    if (!sel_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        result_valid <= 1'b1;
                        ready        <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        seen_low <= seen_low;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_ctrl.sv
module tb_aes_core_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        init, next, encdec, keylen;
    logic        ready, key_valid, result_valid, key_err;
    logic        km_init, km_keylen, km_ready;
    logic [3:0]  km_round;
    logic        enc_next, dec_next, enc_ready, dec_ready;
    logic [3:0]  enc_round, dec_round;
    logic [31:0] km_sboxw, enc_sboxw, sboxw, new_sboxw;
    logic [31:0] km_new_sboxw, enc_new_sboxw;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_core_ctrl #(.KEY_TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .next          (next),
        .encdec        (encdec),
        .keylen        (keylen),
        .ready         (ready),
        .key_valid     (key_valid),
        .result_valid  (result_valid),
        .key_err       (key_err),
        .km_init       (km_init),
        .km_keylen     (km_keylen),
        .km_ready      (km_ready),
        .km_round      (km_round),
        .enc_next      (enc_next),
        .dec_next      (dec_next),
        .enc_ready     (enc_ready),
        .dec_ready     (dec_ready),
        .enc_round     (enc_round),
        .dec_round     (dec_round),
        .km_sboxw      (km_sboxw),
        .enc_sboxw     (enc_sboxw),
        .sboxw         (sboxw),
        .new_sboxw     (new_sboxw),
        .km_new_sboxw  (km_new_sboxw),
        .enc_new_sboxw (enc_new_sboxw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        init      = 1'b0;
        next      = 1'b0;
        encdec    = 1'b0;
        keylen    = 1'b0;
        km_ready  = 1'b1;
        enc_ready = 1'b1;
        dec_ready = 1'b1;
        enc_round = 4'd5;
        dec_round = 4'd9;
        km_sboxw  = 32'hDEAD_BEEF;
        enc_sboxw = 32'h0123_4567;
        new_sboxw = 32'hA5A5_5A5A;
        tick();
        tick();

        // Reset state
        check("rst_ready",        {31'd0, ready},        32'd1);
        check("rst_key_valid",    {31'd0, key_valid},    32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_key_err",      {31'd0, key_err},      32'd0);
        check("rst_km_init",      {31'd0, km_init},      32'd0);
        check("rst_enc_next",     {31'd0, enc_next},     32'd0);
        check("rst_dec_next",     {31'd0, dec_next},     32'd0);
        check("rst_km_keylen",    {31'd0, km_keylen},    32'd0);
        check("rst_km_round",     {28'd0, km_round},     32'd9);
        check("idle_sboxw",       sboxw,                 32'h0123_4567);
        check("fan_km",           km_new_sboxw,          32'hA5A5_5A5A);
        check("fan_enc",          enc_new_sboxw,         32'hA5A5_5A5A);
        reset = 1'b0;
        tick();

        // next without a valid key is ignored
        next = 1'b1; encdec = 1'b1;
        tick();
        next = 1'b0;
        check("nokey_enc_next", {31'd0, enc_next}, 32'd0);
        check("nokey_dec_next", {31'd0, dec_next}, 32'd0);
        check("nokey_ready",    {31'd0, ready},    32'd1);
        tick();
        check("nokey_enc_next2", {31'd0, enc_next}, 32'd0);
        check("nokey_ready2",    {31'd0, ready},    32'd1);

        // Key expansion, AES-128
        init = 1'b1; keylen = 1'b0;
        tick();
        init = 1'b0;
        check("ki_km_init", {31'd0, km_init}, 32'd1);
        check("ki_ready",   {31'd0, ready},   32'd0);
        check("ki_sboxw",   sboxw,            32'hDEAD_BEEF);
        tick();
        check("kw_km_init", {31'd0, km_init}, 32'd0);
        km_ready = 1'b0;
        check("kw_sboxw",   sboxw,            32'hDEAD_BEEF);
        // next during KEY_WAIT must be ignored
        next = 1'b1; encdec = 1'b1;
        tick();
        next = 1'b0;
        check("kw_next_enc", {31'd0, enc_next}, 32'd0);
        check("kw_next_dec", {31'd0, dec_next}, 32'd0);
        check("kw_ready",    {31'd0, ready},    32'd0);
        repeat (10) tick();
        check("kw_key_valid_early", {31'd0, key_valid}, 32'd0);
        check("kw_sboxw_late",      sboxw,              32'hDEAD_BEEF);
        km_ready = 1'b1;
        tick();
        check("kd_key_valid", {31'd0, key_valid}, 32'd1);
        check("kd_ready",     {31'd0, ready},     32'd1);
        check("kd_key_err",   {31'd0, key_err},   32'd0);
        check("kd_sboxw",     sboxw,              32'h0123_4567);

        // Encipher one block
        next = 1'b1; encdec = 1'b1;
        tick();
        next = 1'b0;
        check("enc_enc_next", {31'd0, enc_next},  32'd1);
        check("enc_dec_next", {31'd0, dec_next},  32'd0);
        check("enc_ready0",   {31'd0, ready},     32'd0);
        check("enc_km_round", {28'd0, km_round},  32'd5);
        check("enc_sboxw",    sboxw,              32'h0123_4567);
        tick();
        check("enc_next_once", {31'd0, enc_next}, 32'd0);
        enc_ready = 1'b0;
        tick();
        tick();
        check("enc_rv_early", {31'd0, result_valid}, 32'd0);
        enc_ready = 1'b1;
        tick();
        check("enc_result_valid", {31'd0, result_valid}, 32'd1);
        check("enc_ready1",       {31'd0, ready},        32'd1);

        // Decipher one block
        next = 1'b1; encdec = 1'b0;
        tick();
        next = 1'b0;
        check("dec_dec_next", {31'd0, dec_next},     32'd1);
        check("dec_enc_next", {31'd0, enc_next},     32'd0);
        check("dec_rv_clear", {31'd0, result_valid}, 32'd0);
        check("dec_km_round", {28'd0, km_round},     32'd9);
        tick();
        check("dec_next_once", {31'd0, dec_next}, 32'd0);
        dec_ready = 1'b0;
        tick();
        dec_ready = 1'b1;
        tick();
        check("dec_result_valid", {31'd0, result_valid}, 32'd1);
        check("dec_ready1",       {31'd0, ready},        32'd1);

        // Timeout: km_ready never drops, AES-256 requested
        init = 1'b1; keylen = 1'b1;
        tick();
        init = 1'b0;
        check("to_km_keylen", {31'd0, km_keylen},    32'd1);
        check("to_key_valid", {31'd0, key_valid},    32'd0);
        check("to_rv_clear",  {31'd0, result_valid}, 32'd0);
        tick();
        repeat (63) tick();
        check("to_err_early",   {31'd0, key_err}, 32'd0);
        check("to_ready_early", {31'd0, ready},   32'd0);
        tick();
        check("to_key_err",   {31'd0, key_err},   32'd1);
        check("to_ready",     {31'd0, ready},     32'd1);
        check("to_key_valid2",{31'd0, key_valid}, 32'd0);

        // init and next together: init wins, key_err cleared
        init = 1'b1; next = 1'b1; encdec = 1'b1; keylen = 1'b0;
        tick();
        init = 1'b0; next = 1'b0;
        check("both_km_init",   {31'd0, km_init},   32'd1);
        check("both_enc_next",  {31'd0, enc_next},  32'd0);
        check("both_key_err",   {31'd0, key_err},   32'd0);
        check("both_km_keylen", {31'd0, km_keylen}, 32'd0);
        tick();
        km_ready = 1'b0;
        tick();
        km_ready = 1'b1;
        tick();
        check("both_key_valid", {31'd0, key_valid}, 32'd1);

        // Reset during BLK_WAIT takes effect without a clock edge
        next = 1'b1; encdec = 1'b1;
        tick();
        next = 1'b0;
        tick();
        enc_ready = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_ready",        {31'd0, ready},        32'd1);
        check("arst_key_valid",    {31'd0, key_valid},    32'd0);
        check("arst_result_valid", {31'd0, result_valid}, 32'd0);
        enc_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset during KEY_INIT drops km_init asynchronously
        init = 1'b1;
        tick();
        init = 1'b0;
        check("arst2_km_init_on", {31'd0, km_init}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst2_km_init_off", {31'd0, km_init}, 32'd0);
        check("arst2_sboxw",       sboxw,            32'h0123_4567);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_core_ctrl.md
Name: aes_core_ctrl

Overview:
Top-level sequencer for the AES core. It accepts init/next commands from the host interface and runs the round-key memory expansion (AES-128/256), then launches single-block encipher/decipher operations. It also arbitrates the single shared 32-bit S-box word port between the key-memory generator and the encipher round datapath. It sits between the host-facing wrapper and the aes_key_mem / encipher / decipher blocks.

Parameters:
KEY_TIMEOUT, 64, max cycles in KEY_WAIT before abort with key_err.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
init  in  1  host command: expand key (single-cycle pulse)
next  in  1  host command: process one block (single-cycle pulse)
encdec  in  1  1=encipher, 0=decipher; sampled with next
keylen  in  1  0=128-bit, 1=256-bit; sampled with init
ready  out  1  controller idle and able to accept a command
key_valid  out  1  round keys expanded and usable
result_valid  out  1  block result available; cleared by next/init
key_err  out  1  sticky; key expansion timed out; cleared by init
km_init  out  1  init strobe to key memory
km_keylen  out  1  latched keylen to key memory
km_ready  in  1  key memory ready
km_round  out  4  round index to key memory read port
enc_next  out  1  start strobe to encipher datapath
dec_next  out  1  start strobe to decipher datapath
enc_ready  in  1  encipher datapath ready
dec_ready  in  1  decipher datapath ready
enc_round  in  4  encipher current round
dec_round  in  4  decipher current round
km_sboxw  in  32  S-box request word from key memory
enc_sboxw  in  32  S-box request word from encipher
sboxw  out  32  word to shared S-box
new_sboxw  in  32  substituted word from shared S-box
km_new_sboxw  out  32  substituted word routed to key memory
enc_new_sboxw  out  32  substituted word routed to encipher

Behaviour:
- Reset values: state IDLE, ready=1, key_valid=0, result_valid=0, key_err=0, km_keylen=0, encdec_reg=0, timeout counter=0, seen_low=0, all strobes 0.
- States: IDLE, KEY_INIT, KEY_WAIT, BLK_START, BLK_WAIT.
- IDLE: init=1 -> latch keylen into km_keylen, clear key_valid, key_err, result_valid; ready<=0 -> KEY_INIT. Else next=1 and key_valid=1 -> latch encdec, clear result_valid, ready<=0 -> BLK_START. next with key_valid=0: ignored; ready stays 1.
- init and next both high in IDLE: init wins; next is dropped.
- KEY_INIT: km_init=1 for exactly this one cycle; clear counter and seen_low -> KEY_WAIT.
- KEY_WAIT: counter increments each cycle. km_ready=0 sets seen_low. km_ready=1 with seen_low=1 -> key_valid<=1, ready<=1 -> IDLE. Counter reaching KEY_TIMEOUT-1 without completion -> key_err<=1, ready<=1 -> IDLE.
- BLK_START: enc_next=encdec_reg, dec_next=!encdec_reg, for one cycle; clear seen_low -> BLK_WAIT.
- BLK_WAIT: the selected datapath ready low sets seen_low; ready high with seen_low=1 -> result_valid<=1, ready<=1 -> IDLE. No timeout.
- init or next outside IDLE: ignored, with no state change.
- S-box arbitration: owner=key memory in KEY_INIT/KEY_WAIT, else encipher. sboxw=owner request word. new_sboxw is fanned to both km_new_sboxw and enc_new_sboxw unconditionally. The arbitration is combinational from state, with zero added latency.
- km_round = encdec_reg ? enc_round : dec_round (combinational).
- Strobes are pure decodes of state. All other outputs are registered.
- Reset asserted mid-operation: immediate return to reset values. Strobes deassert asynchronously.

Decomposition:
- Shared package aes_pkg: state encodings, AES_128_BIT_KEY/AES_256_BIT_KEY, ENCIPHER/DECIPHER constants.
- One optional sub-module, aes_sbox_arb: combinational S-box word mux and fan-out, selected by the owner bit. The FSM stays in aes_core_ctrl.

Test Plan:
- Reset, then init with keylen=0. Key-memory model drops km_ready 1 cycle after km_init and raises it after 12 cycles -> km_init high exactly 1 cycle; key_valid=1 and ready=1 one cycle after km_ready rises; sboxw tracks km_sboxw=0xDEADBEEF during KEY_WAIT.
- next with key_valid=0 -> no enc_next/dec_next; ready stays 1; state IDLE.
- After key valid, next with encdec=1 -> enc_next 1 cycle, dec_next=0; sboxw follows enc_sboxw=0x01234567; km_round=enc_round; result_valid=1 after enc_ready re-rises. Repeat with encdec=0: dec_next pulses and km_round=dec_round.
- init with km_ready held at 1 (never low) -> after 64 cycles key_err=1, key_valid=0, ready=1. A following init clears key_err.
- init and next high in the same IDLE cycle -> km_init pulses, no enc_next. A next pulse issued during KEY_WAIT is ignored.
- Reset asserted during BLK_WAIT -> ready=1, key_valid=0, result_valid=0 immediately, without waiting for a clock edge.
